// File: rtl/sliced_cmp.sv
// sliced_cmp: multi-cycle branch comparator that scans operands one SLICE at a time, MSB slice first.
// Optional early termination on the first differing slice is enabled by defining SLICED_CMP_EARLY_EXIT_EN.

package sliced_cmp_pkg;
  typedef logic [2:0] branch_funct3_t;

  localparam branch_funct3_t F3_BEQ  = 3'b000;
  localparam branch_funct3_t F3_BNE  = 3'b001;
  localparam branch_funct3_t F3_BLT  = 3'b100;
  localparam branch_funct3_t F3_BGE  = 3'b101;
  localparam branch_funct3_t F3_BLTU = 3'b110;
  localparam branch_funct3_t F3_BGEU = 3'b111;
endpackage

module sliced_cmp
  import sliced_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  branch_funct3_t   cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             out
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

`ifdef SLICED_CMP_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  branch_funct3_t   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             out_q, out_d;

  logic [SLICE-1:0] slice_a, slice_b;
  logic             top_signed;
  logic             slice_differ;
  logic             slice_lt;
  int unsigned      base;

  function automatic logic branch_result(input branch_funct3_t op, input logic eq, input logic lt);
    logic r;
    unique case (op)
      F3_BEQ:          r = eq;
      F3_BNE:          r = !eq;
      F3_BLT, F3_BLTU: r = lt;
      // bge/bgeu and the reserved encodings 010/011 all resolve as "greater or equal"
      default:         r = !lt;
    endcase
    return r;
  endfunction

  always_comb begin
    base         = 32'(idx_q) * SLICE;
    slice_a      = a_q[base +: SLICE];
    slice_b      = b_q[base +: SLICE];
    top_signed   = (idx_q == IDXW'(N - 1)) && ((op_q == F3_BLT) || (op_q == F3_BGE));
    slice_differ = (slice_a != slice_b);
    slice_lt     = top_signed ? ($signed(slice_a) < $signed(slice_b)) : (slice_a < slice_b);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    eq_d         = eq_q;
    lt_d         = lt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    out_d        = out_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d        = cmpop;
          a_d         = a;
          b_d         = b;
          idx_d       = IDXW'(N - 1);
          eq_d        = 1'b1;
          lt_d        = 1'b0;
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        // Only the most significant differing slice decides the ordering
        if (eq_q && slice_differ) begin
          eq_d = 1'b0;
          lt_d = slice_lt;
        end
        if ((idx_q == '0) || (EarlyExit && eq_q && slice_differ)) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          out_d        = branch_result(op_q, eq_d, lt_d);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          out_d        = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        out_d        = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      eq_q         <= 1'b1;
      lt_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      out_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      out_q        <= out_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign out        = out_q;

endmodule

// File: tb/tb_sliced_cmp.sv
// Self-checking bench for sliced_cmp: directed cases plus randomized operations against an arithmetic model.

module tb_sliced_cmp;
  import sliced_cmp_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SLICE = 8;
  localparam int unsigned N     = WIDTH / SLICE;

`ifdef SLICED_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       cmpop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resp_valid;
  logic             resp_ready;
  logic             out;

  int n_cmp = 0;
  int n_bad = 0;

  sliced_cmp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cmpop      (cmpop),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic comparison, no slicing involved
  function automatic logic model_out(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) < $signed(y);
      3'b101:  return !($signed(x) < $signed(y));
      3'b110:  return x < y;
      default: return !(x < y);
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
    int first_diff_lat;
    first_diff_lat = N;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (((x >> (i * SLICE)) & 32'hFF) != ((y >> (i * SLICE)) & 32'hFF)) begin
        first_diff_lat = int'(N) - i;
        break;
      end
    end
    return EARLY ? first_diff_lat : int'(N);
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    int lat;
    logic exp_out;
    exp_out = model_out(op, x, y);
    check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    cmpop     = op;
    a         = x;
    b         = y;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cmpop     = 3'($urandom_range(0, 7));
    a         = $urandom;
    b         = $urandom;
    check({tag, "_accepted"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      check({tag, "_out_low_busy"}, 32'(out), 32'd0);
      @(posedge clk); #1;
      lat++;
      // operands presented during BUSY must be ignored
      req_valid = 1'b1;
      a         = $urandom;
    end
    req_valid = 1'b0;
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(model_lat(x, y)));
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_out"}, 32'(out), 32'(exp_out));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    a          = $urandom;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, "_idle_after"}, 32'(req_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_out_drop"}, 32'(out), 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          mode, k;

    rst_n      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    cmpop      = '0;
    a          = '0;
    b          = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    run_op("beq_eq", F3_BEQ, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    run_op("blt_neg", F3_BLT, 32'h80000000, 32'h00000001, 0);
    run_op("bltu_big", F3_BLTU, 32'h80000000, 32'h00000001, 0);
    run_op("bne_top", F3_BNE, 32'h12345678, 32'h02345678, 1);
    run_op("bge_hold", F3_BGE, 32'h00000005, 32'hFFFFFFFF, 5);
    run_op("f3_011", 3'b011, 32'h00000001, 32'h00000002, 0);
    run_op("f3_010", 3'b010, 32'h00000003, 32'h00000002, 0);
    run_op("bgeu_eq", F3_BGEU, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    run_op("blt_low", F3_BLT, 32'h7FFFFF00, 32'h7FFFFF01, 0);

    // Reset while BUSY must discard the operation
    cmpop     = F3_BEQ;
    a         = 32'h11111111;
    b         = 32'h11111111;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_late", 32'(resp_valid), 32'd0);
      check("midrst_idle", 32'(req_ready), 32'd1);
    end

    for (int t = 0; t < 40; t++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      mode = int'($urandom_range(0, 2));
      k    = int'($urandom_range(0, N - 1));
      if (mode == 0) rb = ra;
      else if (mode == 1) rb = $urandom;
      else rb = ra ^ ((32'($urandom_range(1, 255))) << (k * SLICE));
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sliced_cmp.md
SLICED_CMP -- requirements
Module: sliced_cmp

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide parameter SLICE, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port req_valid  input  1  request present.
REQ-006 SHALL provide port req_ready  output  1  block can accept a request.
REQ-007 SHALL provide port cmpop  input  branch_funct3_t (3)  beq, bne, blt, bge, bltu, bgeu.
REQ-008 SHALL provide ports a and b  input  WIDTH  operands.
REQ-009 SHALL provide port resp_valid  output  1  result present.
REQ-010 SHALL provide port resp_ready  input  1  consumer accepts the result.
REQ-011 SHALL provide port out  output  1  branch-taken result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; req_ready=1 only in IDLE, and resp_valid=1 only in DONE.
REQ-013 In IDLE, req_valid=1 at an edge SHALL capture cmpop, a and b, set slice index to N-1 and enter BUSY.
REQ-014 In BUSY, each edge SHALL compare slice [idx*SLICE +: SLICE] and decrement idx; the edge processing idx=0 SHALL enter DONE.
REQ-015 Latency SHALL be N edges from accept to resp_valid=1 (4 for defaults).
REQ-016 Running flags SHALL be eq and lt: while eq=1, a differing slice SHALL clear eq and set lt from that slice's compare; once eq=0, the flags SHALL hold.
REQ-017 The top slice SHALL be compared signed for blt/bge and unsigned for bltu/bgeu; all other slices SHALL be compared unsigned.
REQ-018 out SHALL be: beq=eq; bne=!eq; blt/bltu=lt; bge/bgeu=!lt; funct3 010/011 SHALL behave as bgeu.
REQ-019 In DONE, out and resp_valid SHALL hold stable until resp_ready=1; that edge SHALL return the FSM to IDLE, with no same-cycle re-accept.
REQ-020 req_valid, a, b and cmpop SHALL be ignored outside IDLE; captured operands SHALL NOT change during BUSY or DONE.
REQ-021 out SHALL be 0 whenever resp_valid=0.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, idx=0, eq=1, lt=0, captured operands 0, resp_valid=0 and out=0; req_ready SHALL be 1 while rst_n=0 is held.
REQ-023 Reset asserted in BUSY or DONE SHALL discard the operation; no resp_valid SHALL follow for it.
REQ-024 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro SLICED_CMP_EARLY_EXIT_EN defined: the BUSY edge at which eq first clears SHALL enter DONE directly; latency SHALL be N-idx edges, where idx is the first differing slice.
REQ-026 Macro SLICED_CMP_EARLY_EXIT_EN undefined: latency SHALL always be exactly N edges, regardless of data.
REQ-027 Results SHALL be identical with and without the macro.

Verification (WIDTH=32, SLICE=8)
REQ-028 beq, a=b=0xDEADBEEF -> resp_valid 4 edges after accept, out=1.
REQ-029 blt, a=0x80000000, b=0x00000001 -> out=1; bltu with same operands -> out=0.
REQ-030 bne, a=0x12345678, b=0x02345678 -> out=1; resp_valid after 1 edge with the macro, after 4 edges without it.
REQ-031 bge, a=0x00000005, b=0xFFFFFFFF, resp_ready=0 for 5 cycles -> out=1 and resp_valid stable, req_ready=0 throughout, IDLE one edge after resp_ready=1.
REQ-032 funct3=3'b011, a=0x00000001, b=0x00000002 -> out=0 (bgeu); rst_n pulsed low mid-BUSY -> resp_valid=0 and req_ready=1 immediately, no late response.
